// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory request/done bus between mem_access (master) and the memory (slave)
interface mem_access_if #(
  parameter int W = 16
);
  logic         mem_en;
  logic         mem_wr;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_stall;
  logic         mem_done;
  logic [W-1:0] mem_rdata;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_stall, mem_done, mem_rdata
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_stall, mem_done, mem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-stage load/store controller with stall generation
// Optional WAIT watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access #(
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid_in,
  input  logic         req_rd_in,
  input  logic         req_wr_in,
  input  logic         halt_in,
  input  logic [W-1:0] addr_in,
  input  logic [W-1:0] wdata_in,
  mem_access_if.master mem,
  output logic         stall_o,
  output logic         wait_o,
  output logic [W-1:0] ReadData_o,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t       state;
  state_t       state_nxt;
  logic         lat_wr;
  logic [W-1:0] lat_addr;
  logic [W-1:0] lat_wdata;
  logic         access;
  logic         misaligned;
  logic         issue;
  logic         timeout;

  assign access     = req_valid_in & (req_rd_in | req_wr_in) & ~halt_in;
  assign misaligned = access & addr_in[0];
  assign issue      = (state == IDLE) & access & ~addr_in[0] & ~rst;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Held at zero outside WAIT so it always starts clean on entry.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == WAIT) & ~mem.mem_done & (wait_cnt == CW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    mem.mem_en    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    stall_o       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (issue) begin
            mem.mem_en    = 1'b1;
            mem.mem_wr    = req_wr_in;
            mem.mem_addr  = addr_in;
            mem.mem_wdata = wdata_in;
            stall_o       = 1'b1;
            state_nxt     = mem.mem_stall ? REQ : WAIT;
          end
        end
        REQ: begin
          mem.mem_en    = 1'b1;
          mem.mem_wr    = lat_wr;
          mem.mem_addr  = lat_addr;
          mem.mem_wdata = lat_wdata;
          stall_o       = 1'b1;
          if (!mem.mem_stall) state_nxt = WAIT;
        end
        WAIT: begin
          stall_o = 1'b1;
          if (mem.mem_done || timeout) state_nxt = DONE;
        end
        // One unstalled cycle lets the pipeline retire the instruction without re-issuing it.
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign wait_o = stall_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      ReadData_o <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        lat_wr    <= req_wr_in;
        lat_addr  <= addr_in;
        lat_wdata <= wdata_in;
      end
      if (state == WAIT && mem.mem_done) begin
        if (!lat_wr) ReadData_o <= mem.mem_rdata;
      end else if (timeout) begin
        ReadData_o <= '0;
      end
      if ((state == IDLE && misaligned) || timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access against a word-array memory model
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_rd, req_wr, halt;
  logic [15:0] addr, wdata;
  logic        stall_o, wait_o, err;
  logic [15:0] rdata_o;

  int          n_pass = 0;
  int          n_fail = 0;
  logic [15:0] model_mem [0:255];
  logic [15:0] exp_rdata;
  logic        exp_err;

  mem_access_if #(.W(16)) mem_bus ();

  mem_access #(.W(16), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_in (req_valid),
    .req_rd_in    (req_rd),
    .req_wr_in    (req_wr),
    .halt_in      (halt),
    .addr_in      (addr),
    .wdata_in     (wdata),
    .mem          (mem_bus.master),
    .stall_o      (stall_o),
    .wait_o       (wait_o),
    .ReadData_o   (rdata_o),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic h,
                       input logic [15:0] a, input logic [15:0] d);
    req_valid = v; req_rd = rd; req_wr = wr; halt = h; addr = a; wdata = d;
  endtask

  // Aligned load/store: S cycles of mem_stall, mem_done L cycles after acceptance.
  task automatic do_access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                           input int s, input int l);
    logic [7:0] idx;
    idx = a[8:1];
    @(posedge clk); #1;
    drive(1'b1, ~wr, wr, 1'b0, a, d);
    mem_bus.mem_stall = (s > 0);
    mem_bus.mem_done  = 1'b0;
    @(negedge clk);
    chk("issue_en", {15'd0, mem_bus.mem_en}, 16'd1);
    chk("issue_wr", {15'd0, mem_bus.mem_wr}, {15'd0, wr});
    chk("issue_addr", mem_bus.mem_addr, a);
    if (wr) chk("issue_wdata", mem_bus.mem_wdata, d);
    chk("issue_stall", {15'd0, stall_o}, 16'd1);
    for (int i = 1; i <= s; i++) begin
      @(posedge clk); #1;
      mem_bus.mem_stall = (i < s);
      @(negedge clk);
      chk("req_en", {15'd0, mem_bus.mem_en}, 16'd1);
      chk("req_wr", {15'd0, mem_bus.mem_wr}, {15'd0, wr});
      chk("req_addr", mem_bus.mem_addr, a);
      if (wr) chk("req_wdata", mem_bus.mem_wdata, d);
      chk("req_stall", {15'd0, stall_o}, 16'd1);
    end
    if (wr) model_mem[idx] = d;
    for (int k = 1; k <= l; k++) begin
      @(posedge clk); #1;
      mem_bus.mem_stall = 1'b0;
      mem_bus.mem_done  = (k == l);
      mem_bus.mem_rdata = (k == l) ? model_mem[idx] : 16'($urandom);
      @(negedge clk);
      chk("wait_en", {15'd0, mem_bus.mem_en}, 16'd0);
      chk("wait_stall", {15'd0, wait_o}, 16'd1);
    end
    if (!wr) exp_rdata = model_mem[idx];
    @(posedge clk); #1;
    mem_bus.mem_done  = 1'b0;
    mem_bus.mem_rdata = 16'($urandom);
    @(negedge clk);
    chk("done_stall", {15'd0, stall_o}, 16'd0);
    chk("done_wait", {15'd0, wait_o}, 16'd0);
    chk("done_no_reissue", {15'd0, mem_bus.mem_en}, 16'd0);
    chk("done_rdata", rdata_o, exp_rdata);
    chk("done_err", {15'd0, err}, {15'd0, exp_err});
  endtask

  // One cycle of a non-access instruction, with a stray mem_done pulse that must be ignored.
  task automatic idle_cycle(input logic v, input logic rd, input logic wr, input logic h,
                            input logic [15:0] a);
    @(posedge clk); #1;
    drive(v, rd, wr, h, a, 16'($urandom));
    mem_bus.mem_stall = 1'($urandom);
    mem_bus.mem_done  = 1'($urandom);
    mem_bus.mem_rdata = 16'($urandom);
    @(negedge clk);
    chk("nop_en", {15'd0, mem_bus.mem_en}, 16'd0);
    chk("nop_stall", {15'd0, stall_o}, 16'd0);
    chk("nop_rdata", rdata_o, exp_rdata);
    chk("nop_err", {15'd0, err}, {15'd0, exp_err});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 16'($urandom);
    exp_rdata = 16'd0;
    exp_err   = 1'b0;
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
    mem_bus.mem_stall = 1'b0; mem_bus.mem_done = 1'b1; mem_bus.mem_rdata = 16'hFFFF;
    @(negedge clk);
    chk("rst_en", {15'd0, mem_bus.mem_en}, 16'd0);
    chk("rst_wr", {15'd0, mem_bus.mem_wr}, 16'd0);
    chk("rst_addr", mem_bus.mem_addr, 16'd0);
    chk("rst_wdata", mem_bus.mem_wdata, 16'd0);
    chk("rst_stall", {15'd0, stall_o}, 16'd0);
    chk("rst_wait", {15'd0, wait_o}, 16'd0);
    chk("rst_rdata", rdata_o, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    mem_bus.mem_done = 1'b0;

    // Load 0x0010, done at T+3, rdata 0xBEEF
    model_mem[8'h08] = 16'hBEEF;
    do_access(1'b0, 16'h0010, 16'h0000, 0, 3);
    chk("beef_rdata", rdata_o, 16'hBEEF);

    // Store 0x0020 <- 0x1234 with two stall cycles
    do_access(1'b1, 16'h0020, 16'h1234, 2, 2);
    chk("store_keeps_rdata", rdata_o, 16'hBEEF);

    // ADD then HALT with rd set
    idle_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0042);
    idle_cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0044);

    // Read back the stored word
    do_access(1'b0, 16'h0020, 16'h0000, 1, 1);
    chk("readback", rdata_o, 16'h1234);

    for (int n = 0; n < 30; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0)      idle_cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      else if (kind == 1) idle_cycle(1'b1, 1'b1, 1'($urandom), 1'b1, 16'($urandom));
      else if (kind == 2) idle_cycle(1'b1, 1'b0, 1'b0, 1'($urandom), 16'($urandom));
      else do_access(1'($urandom), 16'($urandom_range(0, 255)) << 1, 16'($urandom),
                     $urandom_range(0, 3), $urandom_range(1, 5));
    end

    // Misaligned load
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0011, 16'h0);
    mem_bus.mem_stall = 1'b0; mem_bus.mem_done = 1'b0;
    @(negedge clk);
    chk("mis_en", {15'd0, mem_bus.mem_en}, 16'd0);
    chk("mis_stall", {15'd0, stall_o}, 16'd0);
    chk("mis_err_same_cycle", {15'd0, err}, 16'd0);
    exp_err = 1'b1;
    idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("mis_err_next", {15'd0, err}, 16'd1);

    // Reset during WAIT, then a stray mem_done
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0);
    @(negedge clk);
    chk("rw_issue", {15'd0, mem_bus.mem_en}, 16'd1);
    repeat (2) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      chk("rw_wait_stall", {15'd0, stall_o}, 16'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rw_rst_stall", {15'd0, stall_o}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_bus.mem_done = 1'b1; mem_bus.mem_rdata = 16'hDEAD;
    exp_rdata = 16'd0; exp_err = 1'b0;
    @(negedge clk);
    chk("rw_idle_stall", {15'd0, stall_o}, 16'd0);
    chk("rw_idle_en", {15'd0, mem_bus.mem_en}, 16'd0);
    chk("rw_rdata", rdata_o, 16'd0);
    chk("rw_err", {15'd0, err}, 16'd0);
    @(posedge clk); #1;
    mem_bus.mem_done = 1'b0;
    @(negedge clk);
    chk("rw_pulse_ignored", rdata_o, 16'd0);
    chk("rw_still_idle", {15'd0, stall_o}, 16'd0);

    for (int n = 0; n < 6; n++)
      do_access(1'($urandom), 16'($urandom_range(0, 255)) << 1, 16'($urandom),
                $urandom_range(0, 2), $urandom_range(1, 4));

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Watchdog: load with no mem_done
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
    mem_bus.mem_stall = 1'b0; mem_bus.mem_done = 1'b0;
    @(negedge clk);
    chk("to_issue", {15'd0, mem_bus.mem_en}, 16'd1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_wait_stall", {15'd0, stall_o}, 16'd1);
      chk("to_wait_err", {15'd0, err}, 16'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_done_stall", {15'd0, stall_o}, 16'd0);
    chk("to_done_err", {15'd0, err}, 16'd1);
    chk("to_done_rdata", rdata_o, 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
